scanner_link_arbiter: RTL and testbench
=======================================

SCANNER_LINK_ARBITER -- requirements
Module: scanner_link_arbiter

Interface
REQ-001 Parameter: FRAME_W, 8, bits per serial byte (command or data).
REQ-002 Parameter: GAP_CYC, 2, idle clk cycles forced between frames.
REQ-003 clk  in  1  single system clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req  in  2  per-scanner frame request; bit i = scanner i; held until done[i].
REQ-006 reqIsData  in  2  bit i = 1: frame i is command byte followed by data byte; 0: command only.
REQ-007 cmd0, cmd1  in  FRAME_W  command byte of scanner 0/1, sampled at grant.
REQ-008 data0, data1  in  FRAME_W  data byte of scanner 0/1, sampled at grant.
REQ-009 grant  out  2  one-hot owner of the link; held for the whole frame.
REQ-010 done  out  2  one-cycle pulse to scanner i when its frame's last bit has completed.
REQ-011 clkOut  out  1  serial link clock; data valid on its rising edge.
REQ-012 dataOut  out  1  serial link data, LSB first.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 FSM states SHALL be IDLE, CMD, DATA, GAP; all outputs registered.
REQ-015 IDLE: if req != 0, next edge SHALL enter CMD, set grant, latch cmd/data/reqIsData of the winner into internal registers.
REQ-016 Arbitration SHALL be round-robin: with both req bits high, the requester not granted last wins; single request wins outright.
REQ-017 Round-robin pointer SHALL update only when a grant is issued.
REQ-018 Each bit SHALL occupy 2 clk cycles: phase 0 clkOut=0 with dataOut updated; phase 1 clkOut=1 with dataOut stable.
REQ-019 CMD SHALL shift FRAME_W bits (2*FRAME_W cycles) of the latched command, bit 0 first.
REQ-020 After CMD's last phase 1: latched reqIsData=1 -> DATA; else -> GAP.
REQ-021 DATA SHALL shift the latched data byte identically, then -> GAP.
REQ-022 On the edge entering GAP: done[owner] pulses 1 cycle, grant clears, clkOut=0, dataOut=0.
REQ-023 GAP SHALL last GAP_CYC cycles, ignoring req, then -> IDLE.
REQ-024 Latency: req sampled high in IDLE at edge t -> grant and first dataOut bit at t+1; clkOut first high at t+2.
REQ-025 Frame length: 2*FRAME_W (cmd only) or 4*FRAME_W (cmd+data) cycles from grant to done.
REQ-026 Deasserting req mid-frame SHALL NOT abort the frame; done still pulses.
REQ-027 Changes to cmd*/data*/reqIsData after grant SHALL have no effect on the current frame.
REQ-028 req held high after done SHALL be treated as a new request at the next IDLE.
REQ-029 Bit counter SHALL be log2(FRAME_W) bits wide and wrap to 0 at byte end without overflow side effects.
REQ-030 Outside CMD/DATA, clkOut SHALL be 0 and dataOut 0.

Reset
REQ-031 rst SHALL immediately force state IDLE, grant=0, done=0, clkOut=0, dataOut=0, busy=0, bit counter 0, phase 0.
REQ-032 Round-robin pointer SHALL reset so scanner 0 wins the first simultaneous request.
REQ-033 Reset mid-frame SHALL drop the frame with no done pulse; the scanner re-requests.

Structure
REQ-034 Shared package scanner_pkg SHALL hold the state enum, FRAME_W default, and command codes CMD_READY=2, CMD_START=3, CMD_FULL=4, CMD_DATA=7.
REQ-035 Serializer (shift register, bit counter, phase toggle) SHALL be a sub-module link_serializer; arbitration and FSM remain in the top.

Verification
REQ-036 req=01, reqIsData=00, cmd0=0x04 -> grant=01 next cycle; dataOut bits 0,0,1,0,0,0,0,0 on 8 clkOut rising edges; done[0] after 16 cycles; 2 GAP cycles.
REQ-037 req=10, reqIsData=10, cmd1=0x07, data1=0xA5 -> 16 clkOut pulses: 0x07 LSB-first then 0xA5 LSB-first; done[1] after 32 cycles.
REQ-038 req=11 from reset, held -> grant order 01,10,01; each done pulse matches the granted bit.
REQ-039 cmd0 changed 0x02->0x03 and req[0] dropped mid-frame -> full 0x02 frame transmitted, done[0] pulses.
REQ-040 rst asserted at bit 3 of CMD (not clock-aligned) -> all outputs 0 immediately, no done, next req=01 starts a clean frame.

Source files
------------

// File: rtl/scanner_pkg.sv
// Shared types and constants for the scanner serial-link arbiter.
package scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  localparam int FRAME_W_DEF = 8;

  localparam logic [7:0] CMD_READY = 8'd2;
  localparam logic [7:0] CMD_START = 8'd3;
  localparam logic [7:0] CMD_FULL  = 8'd4;
  localparam logic [7:0] CMD_DATA  = 8'd7;

endpackage

// File: rtl/link_serializer.sv
// Shifts one byte out LSB first, two clk cycles per bit (clock low, then clock high).
module link_serializer
  import scanner_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic [FRAME_W-1:0] byte_i,
  output logic               sclk_o,
  output logic               sdat_o,
  output logic               last_o
);

  localparam int CNT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

  logic [FRAME_W-1:0] shift_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               phase_q;
  logic               active_q;
  logic               sclk_q;
  logic               sdat_q;
  logic               cnt_end;

  assign cnt_end = (cnt_q == CNT_W'(FRAME_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      active_q <= 1'b0;
      sclk_q   <= 1'b0;
      sdat_q   <= 1'b0;
    end else if (load_i) begin
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      active_q <= 1'b1;
      sclk_q   <= 1'b0;
      sdat_q   <= byte_i[0];
    end else if (clear_i) begin
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      active_q <= 1'b0;
      sclk_q   <= 1'b0;
      sdat_q   <= 1'b0;
    end else if (active_q) begin
      if (!phase_q) begin
        phase_q <= 1'b1;
        sclk_q  <= 1'b1;
      end else begin
        phase_q <= 1'b0;
        sclk_q  <= 1'b0;
        sdat_q  <= shift_q[0];
        cnt_q   <= cnt_end ? '0 : cnt_q + 1'b1;
      end
    end
  end

  // Bit 0 goes straight to the output on load, so the register holds the remaining bits.
  always_ff @(posedge clk) begin
    if (load_i) begin
      shift_q <= byte_i >> 1;
    end else if (active_q && phase_q) begin
      shift_q <= shift_q >> 1;
    end
  end

  assign sclk_o = sclk_q;
  assign sdat_o = sdat_q;
  assign last_o = active_q & phase_q & cnt_end;

endmodule

// File: rtl/scanner_link_arbiter.sv
// Round-robin arbiter granting one of two scanners a shared serial link for a
// command byte, optionally followed by a data byte, then a fixed idle gap.
module scanner_link_arbiter
  import scanner_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int GAP_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req,
  input  logic [1:0]         reqIsData,
  input  logic [FRAME_W-1:0] cmd0,
  input  logic [FRAME_W-1:0] cmd1,
  input  logic [FRAME_W-1:0] data0,
  input  logic [FRAME_W-1:0] data1,
  output logic [1:0]         grant,
  output logic [1:0]         done,
  output logic               clkOut,
  output logic               dataOut,
  output logic               busy
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_e             state_q;
  logic [1:0]         grant_q;
  logic [1:0]         done_q;
  logic               busy_q;
  logic               last_win_q;
  logic               isdata_q;
  logic [GAP_W-1:0]   gap_q;
  logic [FRAME_W-1:0] data_q;

  logic               win;
  logic               ser_load;
  logic               ser_clear;
  logic               ser_last;
  logic [FRAME_W-1:0] ser_byte;

  // Scanner 1 wins when it is the only requester, or on a tie when scanner 0 was served last.
  assign win = req[1] & (~req[0] | ~last_win_q);

  always_comb begin
    ser_load  = 1'b0;
    ser_clear = 1'b0;
    ser_byte  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          ser_load = 1'b1;
          ser_byte = win ? cmd1 : cmd0;
        end
      end
      ST_CMD: begin
        if (ser_last) begin
          if (isdata_q) ser_load  = 1'b1;
          else          ser_clear = 1'b1;
        end
      end
      ST_DATA: begin
        if (ser_last) ser_clear = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      last_win_q <= 1'b1;
      isdata_q   <= 1'b0;
      gap_q      <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            state_q    <= ST_CMD;
            grant_q    <= win ? 2'b10 : 2'b01;
            last_win_q <= win;
            isdata_q   <= reqIsData[win];
            busy_q     <= 1'b1;
          end
        end
        ST_CMD: begin
          if (ser_last) begin
            if (isdata_q) begin
              state_q <= ST_DATA;
            end else begin
              state_q <= ST_GAP;
              done_q  <= grant_q;
              grant_q <= '0;
              gap_q   <= '0;
            end
          end
        end
        ST_DATA: begin
          if (ser_last) begin
            state_q <= ST_GAP;
            done_q  <= grant_q;
            grant_q <= '0;
            gap_q   <= '0;
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_W'(GAP_CYC - 1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // The data byte is captured with the grant so later input changes cannot leak into the frame.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && (|req)) begin
      data_q <= win ? data1 : data0;
    end
  end

  link_serializer #(
    .FRAME_W(FRAME_W)
  ) u_ser (
    .clk    (clk),
    .rst    (rst),
    .load_i (ser_load),
    .clear_i(ser_clear),
    .byte_i (ser_byte),
    .sclk_o (clkOut),
    .sdat_o (dataOut),
    .last_o (ser_last)
  );

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_scanner_link_arbiter.sv
// Bench for scanner_link_arbiter: frame-position reference model plus directed literal frames.
module tb_scanner_link_arbiter;
  import scanner_pkg::*;

  localparam int FW = 8;
  localparam int GC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req;
  logic [1:0]    reqIsData;
  logic [FW-1:0] cmd0, cmd1, data0, data1;
  logic [1:0]    grant, done;
  logic          clkOut, dataOut, busy;

  int checks   = 0;
  int failures = 0;

  scanner_link_arbiter #(.FRAME_W(FW), .GAP_CYC(GC)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .reqIsData(reqIsData),
    .cmd0     (cmd0),
    .cmd1     (cmd1),
    .data0    (data0),
    .data1    (data1),
    .grant    (grant),
    .done     (done),
    .clkOut   (clkOut),
    .dataOut  (dataOut),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a bit list; outputs follow from the position j since grant.
  bit              m_idle = 1'b1;
  bit              m_last = 1'b1;
  bit              m_win  = 1'b0;
  int              m_j    = 0;
  int              m_len  = 0;
  logic [2*FW-1:0] m_bits = '0;
  logic [1:0]      e_grant = '0;
  logic [1:0]      e_done  = '0;
  logic            e_clk   = 1'b0;
  logic            e_dat   = 1'b0;
  logic            e_busy  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_idle  = 1'b1;
      m_last  = 1'b1;
      e_grant = '0;
      e_done  = '0;
      e_clk   = 1'b0;
      e_dat   = 1'b0;
      e_busy  = 1'b0;
    end else begin
      if (m_idle && req != 2'b00) begin
        m_win  = (req == 2'b11) ? !m_last : req[1];
        m_last = m_win;
        m_bits = m_win ? {data1, cmd1} : {data0, cmd0};
        m_len  = reqIsData[m_win] ? 4 * FW : 2 * FW;
        m_j    = 0;
        m_idle = 1'b0;
      end
      if (!m_idle) begin
        m_j++;
        e_grant = '0;
        e_done  = '0;
        e_clk   = 1'b0;
        e_dat   = 1'b0;
        e_busy  = 1'b1;
        if (m_j <= m_len) begin
          e_grant = m_win ? 2'b10 : 2'b01;
          e_clk   = ((m_j - 1) % 2) == 1;
          e_dat   = m_bits[(m_j - 1) / 2];
        end else if (m_j == m_len + 1) begin
          e_done = m_win ? 2'b10 : 2'b01;
        end else if (m_j == m_len + GC + 1) begin
          e_busy = 1'b0;
          m_idle = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_grant",   32'(grant),   32'(e_grant));
    chk("cmp_done",    32'(done),    32'(e_done));
    chk("cmp_clkOut",  32'(clkOut),  32'(e_clk));
    chk("cmp_dataOut", 32'(dataOut), 32'(e_dat));
    chk("cmp_busy",    32'(busy),    32'(e_busy));
  end

  task automatic capture(input bit mid, output logic [1:0] g, output logic [1:0] d,
                         output int waitc, output int ncyc, output int nbits,
                         output logic [15:0] bits);
    waitc = 0;
    do begin
      @(negedge clk);
      waitc++;
    end while (grant == 2'b00 && waitc < 60);
    chk("grant_wait_bound", 32'(waitc < 60), 1);
    g     = grant;
    ncyc  = 0;
    nbits = 0;
    bits  = '0;
    while (done == 2'b00 && ncyc < 80) begin
      @(negedge clk);
      ncyc++;
      if (mid && ncyc == 5) begin
        cmd0   = CMD_START;
        req[0] = 1'b0;
      end
      if (clkOut && nbits < 16) begin
        bits[nbits] = dataOut;
        nbits++;
      end
    end
    d = done;
  endtask

  task automatic gap_len(output int n);
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  logic [1:0]  g, d;
  logic [15:0] bits;
  int          w, nc, nb, n;

  initial begin
    rst = 1'b1; req = '0; reqIsData = '0;
    cmd0 = '0; cmd1 = '0; data0 = '0; data1 = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({grant, done, clkOut, dataOut, busy}), 0);
    rst = 1'b0;

    // Command-only frame from scanner 0
    req = 2'b01; reqIsData = 2'b00; cmd0 = CMD_FULL;
    capture(1'b0, g, d, w, nc, nb, bits);
    req = 2'b00;
    chk("f1_latency", 32'(w), 1);
    chk("f1_grant", 32'(g), 32'h1);
    chk("f1_done", 32'(d), 32'h1);
    chk("f1_len", 32'(nc), 16);
    chk("f1_nbits", 32'(nb), 8);
    chk("f1_byte", 32'(bits[7:0]), 32'h04);
    gap_len(n);
    chk("f1_gap", 32'(n), GC);

    // Command + data frame from scanner 1
    req = 2'b10; reqIsData = 2'b10; cmd1 = CMD_DATA; data1 = 8'hA5;
    capture(1'b0, g, d, w, nc, nb, bits);
    req = 2'b00;
    chk("f2_grant", 32'(g), 32'h2);
    chk("f2_done", 32'(d), 32'h2);
    chk("f2_len", 32'(nc), 32);
    chk("f2_nbits", 32'(nb), 16);
    chk("f2_bytes", 32'(bits), 32'hA507);
    gap_len(n);

    // Simultaneous requests from reset alternate
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = 2'b11; reqIsData = 2'b00; cmd0 = CMD_READY; cmd1 = CMD_START;
    for (int k = 0; k < 3; k++) begin
      capture(1'b0, g, d, w, nc, nb, bits);
      chk("rr_grant", 32'(g), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("rr_done", 32'(d), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("rr_byte", 32'(bits[7:0]), (k % 2 == 0) ? 32'h02 : 32'h03);
    end
    req = 2'b00;
    gap_len(n);

    // Inputs changed and request dropped mid-frame
    req = 2'b01; reqIsData = 2'b00; cmd0 = CMD_READY;
    capture(1'b1, g, d, w, nc, nb, bits);
    chk("f4_byte", 32'(bits[7:0]), 32'h02);
    chk("f4_done", 32'(d), 32'h1);
    chk("f4_len", 32'(nc), 16);
    gap_len(n);

    // Asynchronous reset in the middle of bit 3
    req = 2'b01; cmd0 = 8'hFF;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (grant == 2'b00 && w < 60);
    chk("f5_grant_wait_bound", 32'(w < 60), 1);
    repeat (6) @(negedge clk);
    chk("f5_bit3_before_rst", 32'({grant, dataOut, busy}), 32'b01_1_1);
    #2 rst = 1'b1;
    #1 chk("rst_async_outputs", 32'({grant, done, clkOut, dataOut, busy}), 0);
    @(negedge clk);
    chk("rst_no_done", 32'(done), 0);
    rst = 1'b0;
    cmd0 = CMD_READY;
    capture(1'b0, g, d, w, nc, nb, bits);
    req = 2'b00;
    chk("f5_latency", 32'(w), 1);
    chk("f5_grant", 32'(g), 32'h1);
    chk("f5_byte", 32'(bits[7:0]), 32'h02);
    chk("f5_done", 32'(d), 32'h1);
    chk("f5_len", 32'(nc), 16);
    gap_len(n);

    // Randomized traffic with occasional asynchronous resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) req[0] = ~req[0];
      if ($urandom_range(0, 7) == 0) req[1] = ~req[1];
      reqIsData = 2'($urandom_range(0, 3));
      cmd0  = 8'($urandom);
      cmd1  = 8'($urandom);
      data0 = 8'($urandom);
      data1 = 8'($urandom);
      if ($urandom_range(0, 699) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    req = 2'b00;
    repeat (60) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
